fc8_mem_arbiter: RTL and testbench

Three-way arbiter that shares the single FC8 physical memory port (20-bit address, 8-bit data, fixed RAM / VRAM / SFR / cartridge ROM map) between the CPU, the DMA engine and the video fetch unit. It sits between the requesters and the memory controller's physical port. It registers one access per cycle onto that port and returns read data to the requester that issued it. Video has fixed priority with a starvation limit; CPU and DMA share the remaining slots round-robin.

---
 rtl/fc8_pkg.sv | 20 ++
 rtl/fc8_arb_pick.sv | 38 +++
 rtl/fc8_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fc8_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc8_pkg.sv
// Shared FC8 memory-system types and constants.
package fc8_pkg;

    localparam int FC8_PADDR_W = 20;
    localparam int FC8_DATA_W  = 8;

    // Bit positions inside the one-hot winner / eligible vectors.
    localparam int WIN_CPU = 0;
    localparam int WIN_DMA = 1;
    localparam int WIN_VID = 2;

    // Owner of a memory access; also used as the round-robin memory.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_VID  = 2'd3
    } owner_t;

endpackage

// File: rtl/fc8_arb_pick.sv
// Combinational winner selection for the FC8 memory port.
module fc8_arb_pick
    import fc8_pkg::*;
#(
    parameter int VID_MAX_RUN = 8
) (
    input  logic [2:0] elig,
    input  logic [3:0] vid_run,
    input  owner_t     rr_last,
    output logic [2:0] win
);

    localparam logic [3:0] RUN_LIMIT = 4'(VID_MAX_RUN);

    logic others;

    assign others = elig[WIN_CPU] | elig[WIN_DMA];

    // Video first unless it has used up its run while someone else waits;
    // then CPU/DMA alternate, a lone requester simply wins.
    always_comb begin
        win = 3'b000;
        if (elig[WIN_VID] && ((vid_run < RUN_LIMIT) || !others)) begin
            win[WIN_VID] = 1'b1;
        end else if (elig[WIN_CPU] && elig[WIN_DMA]) begin
            if (rr_last == OWN_CPU) begin
                win[WIN_DMA] = 1'b1;
            end else begin
                win[WIN_CPU] = 1'b1;
            end
        end else if (elig[WIN_CPU]) begin
            win[WIN_CPU] = 1'b1;
        end else if (elig[WIN_DMA]) begin
            win[WIN_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/fc8_mem_arbiter.sv
// Three-way arbiter (CPU, DMA, video) for the single FC8 memory port.
//
// Handshake: a requester raises *_req with we/addr/wdata stable and holds it.
// *_gnt pulses for one cycle while that command is on the mem_* port; the
// requester may change its command or drop *_req from the next cycle on.
// Reads come back two cycles after *_gnt as a one-cycle *_rvalid pulse with
// *_rdata, in issue order. There is no back-pressure on the return path.
module fc8_mem_arbiter
    import fc8_pkg::*;
#(
    parameter int ADDR_W      = FC8_PADDR_W,
    parameter int DATA_W      = FC8_DATA_W,
    parameter int VID_MAX_RUN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              cpu_gnt,
    output logic              dma_gnt,
    output logic              vid_gnt,
    output logic              cpu_rvalid,
    output logic              dma_rvalid,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] RUN_LIMIT = 4'(VID_MAX_RUN);

    logic [2:0]        elig;
    logic [2:0]        win;
    logic              any_win;
    owner_t            sel_own;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        vid_run;
    owner_t            rr_last;
    owner_t            own_q1;
    owner_t            own_q2;

    // A request whose grant is on the port right now is already served.
    assign elig    = {vid_req & ~vid_gnt, dma_req & ~dma_gnt, cpu_req & ~cpu_gnt};
    assign any_win = |win;

    fc8_arb_pick #(
        .VID_MAX_RUN(VID_MAX_RUN)
    ) u_pick (
        .elig   (elig),
        .vid_run(vid_run),
        .rr_last(rr_last),
        .win    (win)
    );

    // Route the winner's command towards the port registers.
    always_comb begin
        sel_own   = OWN_NONE;
        sel_we    = 1'b0;
        sel_addr  = mem_addr;
        sel_wdata = mem_wdata;
        if (win[WIN_VID]) begin
            sel_own   = OWN_VID;
            sel_addr  = vid_addr;
            sel_wdata = '0;
        end else if (win[WIN_CPU]) begin
            sel_own   = OWN_CPU;
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end else if (win[WIN_DMA]) begin
            sel_own   = OWN_DMA;
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    // Memory port command and grant pulses; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            vid_gnt   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_gnt <= win[WIN_CPU];
            dma_gnt <= win[WIN_DMA];
            vid_gnt <= win[WIN_VID];
            mem_en  <= any_win;
            mem_we  <= any_win & sel_we;
            if (any_win) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    // Fairness state and the read-owner tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_run <= 4'd0;
            rr_last <= OWN_DMA;
            own_q1  <= OWN_NONE;
            own_q2  <= OWN_NONE;
        end else begin
            if (win[WIN_VID]) begin
                if (vid_run < RUN_LIMIT) begin
                    vid_run <= vid_run + 4'd1;
                end
            end else if (win[WIN_CPU] || win[WIN_DMA]) begin
                vid_run <= 4'd0;
            end
            if (win[WIN_CPU]) begin
                rr_last <= OWN_CPU;
            end else if (win[WIN_DMA]) begin
                rr_last <= OWN_DMA;
            end
            own_q1 <= (any_win && !sel_we) ? sel_own : OWN_NONE;
            own_q2 <= own_q1;
        end
    end

    // Steer returning memory data to whichever requester issued the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            vid_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            vid_rdata  <= '0;
        end else begin
            cpu_rvalid <= (own_q2 == OWN_CPU);
            dma_rvalid <= (own_q2 == OWN_DMA);
            vid_rvalid <= (own_q2 == OWN_VID);
            if (own_q2 == OWN_CPU) cpu_rdata <= mem_rdata;
            if (own_q2 == OWN_DMA) dma_rdata <= mem_rdata;
            if (own_q2 == OWN_VID) vid_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fc8_mem_arbiter.sv
// Randomized + directed bench for fc8_mem_arbiter with a cycle-level reference model.
module tb_fc8_mem_arbiter;

    localparam int AW      = 20;
    localparam int DW      = 8;
    localparam int VID_MAX = 8;
    localparam int EW      = 26;  // {due cycle[15:0], owner[1:0], data[7:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          cpu_gnt, dma_gnt, vid_gnt;
    logic          cpu_rvalid, dma_rvalid, vid_rvalid;
    logic [DW-1:0] cpu_rdata, dma_rdata, vid_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    fc8_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .VID_MAX_RUN(VID_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .vid_gnt(vid_gnt),
        .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid), .vid_rvalid(vid_rvalid),
        .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata), .vid_rdata(vid_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // ---------------- memory model ----------------
    // Contents are a fixed function of the address; 0x00010 reads as 0x3C.
    function automatic logic [7:0] mem_val(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h2C;
    endfunction

    // Read data appears the cycle after a read command; junk otherwise.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
        else                   mem_rdata <= 8'($urandom);
    end

    // ---------------- scoreboard / model state ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic          e_cpu_gnt = 1'b0, e_dma_gnt = 1'b0, e_vid_gnt = 1'b0;
    logic          e_en = 1'b0, e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    int            e_rv_own = 0;  // 0 none, 1 cpu, 2 dma, 3 vid
    logic [DW-1:0] e_rdata = '0;
    int            m_run = 0;
    int            m_rr = 2;      // last CPU/DMA winner: 1 cpu, 2 dma
    logic [EW-1:0] exp_q[$];
    int            p_cpu = 0, p_dma = 0, p_vid = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, act, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs now applied.
    task automatic model_step();
        int            w;
        logic          ce, de, ve;
        logic [EW-1:0] ent;
        cyc++;
        e_rv_own = 0;
        if (rst) begin
            e_cpu_gnt = 1'b0; e_dma_gnt = 1'b0; e_vid_gnt = 1'b0;
            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
            m_run = 0; m_rr = 2;
            exp_q.delete();
            return;
        end
        if (exp_q.size() > 0 && exp_q[0][25:10] == cyc[15:0]) begin
            ent      = exp_q.pop_front();
            e_rv_own = int'(ent[9:8]);
            e_rdata  = ent[7:0];
        end
        ce = cpu_req && !e_cpu_gnt;
        de = dma_req && !e_dma_gnt;
        ve = vid_req && !e_vid_gnt;
        w = 0;
        if (ve && (m_run < VID_MAX || !(ce || de))) w = 3;
        else if (ce && de) w = (m_rr == 1) ? 2 : 1;
        else if (ce) w = 1;
        else if (de) w = 2;
        e_cpu_gnt = (w == 1);
        e_dma_gnt = (w == 2);
        e_vid_gnt = (w == 3);
        case (w)
            1: begin e_en = 1'b1; e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata; end
            2: begin e_en = 1'b1; e_we = dma_we; e_addr = dma_addr; e_wdata = dma_wdata; end
            3: begin e_en = 1'b1; e_we = 1'b0;   e_addr = vid_addr; end
            default: begin e_en = 1'b0; e_we = 1'b0; end
        endcase
        if (w == 3) begin
            if (m_run < VID_MAX) m_run++;
        end else if (w != 0) begin
            m_run = 0;
            m_rr  = w;
        end
        if (w != 0 && !e_we) exp_q.push_back({16'(cyc + 2), 2'(w), mem_val(e_addr)});
    endtask

    task automatic do_checks();
        check("cpu_gnt", cpu_gnt, e_cpu_gnt);
        check("dma_gnt", dma_gnt, e_dma_gnt);
        check("vid_gnt", vid_gnt, e_vid_gnt);
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        check("cpu_rvalid", cpu_rvalid, e_rv_own == 1);
        check("dma_rvalid", dma_rvalid, e_rv_own == 2);
        check("vid_rvalid", vid_rvalid, e_rv_own == 3);
        if (e_rv_own == 1) check("cpu_rdata", cpu_rdata, e_rdata);
        if (e_rv_own == 2) check("dma_rdata", dma_rdata, e_rdata);
        if (e_rv_own == 3) check("vid_rdata", vid_rdata, e_rdata);
    endtask

    // ---------------- driver ----------------
    function automatic logic [19:0] rand_addr();
        logic [19:0] a;
        a = (20'($urandom_range(3)) << 16) | 20'($urandom_range(15));
        return a;
    endfunction

    // Requesters drop after the model's grant and may re-request at once.
    task automatic drive_next();
        if (cpu_req && e_cpu_gnt) cpu_req = 1'b0;
        if (dma_req && e_dma_gnt) dma_req = 1'b0;
        if (vid_req && e_vid_gnt) vid_req = 1'b0;
        if (!cpu_req && $urandom_range(99) < p_cpu) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
            cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
        end
        if (!dma_req && $urandom_range(99) < p_dma) begin
            dma_req = 1'b1; dma_we = 1'($urandom_range(1));
            dma_addr = rand_addr(); dma_wdata = 8'($urandom);
        end
        if (!vid_req && $urandom_range(99) < p_vid) begin
            vid_req = 1'b1; vid_addr = rand_addr();
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        do_checks();
        drive_next();
    endtask

    // Let outstanding requests finish and the return pipeline drain.
    task automatic idle(input int n);
        p_cpu = 0; p_dma = 0; p_vid = 0;
        for (int i = 0; i < 40 && (cpu_req || dma_req || vid_req); i++) run_cycle();
        if (cpu_req || dma_req || vid_req) check("idle_drain", 1, 0);
        repeat (n) run_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) run_cycle();
        rst = 1'b0;
        idle(3);

        // Single CPU read of 0x00010.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
        run_cycle();
        check("rd_cpu_gnt", cpu_gnt, 1);
        check("rd_mem_addr", mem_addr, 20'h00010);
        run_cycle();
        run_cycle();
        check("rd_cpu_rvalid", cpu_rvalid, 1);
        check("rd_cpu_rdata", cpu_rdata, 8'h3C);
        idle(3);

        // CPU and DMA contention: port busy every cycle.
        p_cpu = 100; p_dma = 100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rand_addr();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = rand_addr();
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            check("cont_mem_en", mem_en, 1);
        end
        idle(3);

        // DMA write.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 20'h10000; dma_wdata = 8'hA5;
        run_cycle();
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 20'h10000);
        check("wr_mem_wdata", mem_wdata, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check("wr_dma_rvalid", dma_rvalid, 0);
        end
        idle(3);

        // Video starvation limit: saturate the run, then CPU must get in.
        p_vid = 100;
        vid_req = 1'b1; vid_addr = rand_addr();
        repeat (20) run_cycle();
        if (!e_vid_gnt) run_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rand_addr();
        run_cycle();
        check("starve_cpu_gnt", cpu_gnt, 1);
        check("starve_vid_gnt", vid_gnt, 0);
        run_cycle();
        check("starve_vid_resume", vid_gnt, 1);
        idle(3);

        // Back-to-back single requester: grant every other cycle.
        p_cpu = 100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rand_addr();
        for (int i = 1; i <= 6; i++) begin
            run_cycle();
            check("b2b_cpu_gnt", cpu_gnt, (i % 2) == 1);
            check("b2b_mem_en", mem_en, (i % 2) == 1);
        end
        idle(3);

        // Reset while a video read is in flight.
        vid_req = 1'b1; vid_addr = rand_addr();
        run_cycle();
        check("rst_vid_gnt", vid_gnt, 1);
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        check("rst_vid_rvalid", vid_rvalid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rand_addr();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = rand_addr();
        run_cycle();
        check("rst_tie_cpu", cpu_gnt, 1);
        check("rst_tie_dma", dma_gnt, 0);
        idle(3);

        // Randomized traffic with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            p_cpu = $urandom_range(100);
            p_dma = $urandom_range(100);
            p_vid = $urandom_range(100);
            for (int i = 0; i < 25; i++) begin
                rst = ($urandom_range(199) == 0);
                run_cycle();
            end
        end
        rst = 1'b0;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
